cpu_control_fsm: RTL and testbench

//  Multi-cycle control unit for the 16-bit CR16-subset CPU; drives every control input of the datapath.

---
 rtl/cpu_control_fsm_pkg.sv | 70 +++++++
 rtl/cpu_control_fsm_if.sv | 34 +++
 rtl/cpu_control_fsm_decode.sv | 64 ++++++
 rtl/cpu_control_fsm.sv | 134 +++++++++++++
 tb/tb_cpu_control_fsm.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/cpu_control_fsm_pkg.sv
// Shared encodings for the CR16-subset control unit: states, instruction classes, op/ext codes, flags.
// Condition-code evaluation lives here so the decoder and the FSM agree on one definition.
package cpu_control_fsm_pkg;

    typedef enum logic [2:0] {
        ST_FETCH   = 3'd0,
        ST_DECODE  = 3'd1,
        ST_EXEC    = 3'd2,
        ST_LOAD_WB = 3'd3,
        ST_HALT    = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        CL_NOP   = 3'd0,
        CL_ALU   = 3'd1,
        CL_LOAD  = 3'd2,
        CL_STOR  = 3'd3,
        CL_BCOND = 3'd4,
        CL_WAIT  = 3'd5
    } iclass_t;

    localparam logic [3:0] OP_RTYPE  = 4'h0;
    localparam logic [3:0] OP_RTYPE2 = 4'h8;
    localparam logic [3:0] OP_ADDI   = 4'h5;
    localparam logic [3:0] OP_SUBI   = 4'h9;
    localparam logic [3:0] OP_CMPI   = 4'hB;
    localparam logic [3:0] OP_MEM    = 4'h4;
    localparam logic [3:0] OP_BCOND  = 4'hC;
    localparam logic [3:0] OP_LUI    = 4'hF;

    localparam logic [3:0] EXT_ADD  = 4'h5;
    localparam logic [3:0] EXT_SUB  = 4'h9;
    localparam logic [3:0] EXT_CMP  = 4'hB;
    localparam logic [3:0] EXT_LOAD = 4'h0;
    localparam logic [3:0] EXT_STOR = 4'h4;
    localparam logic [3:0] EXT_WAIT = 4'h8;

    // Field order matches the ALU flag bus: [4]N [3]Z [2]F [1]L [0]C.
    typedef struct packed {
        logic n;
        logic z;
        logic f;
        logic l;
        logic c;
    } flags_t;

    function automatic logic cond_met(input logic [3:0] cond, input flags_t fl);
        logic r;
        case (cond)
            4'h0:    r = fl.z;
            4'h1:    r = !fl.z;
            4'h2:    r = fl.c;
            4'h3:    r = !fl.c;
            4'h4:    r = fl.l;
            4'h5:    r = !fl.l;
            4'h6:    r = fl.n;
            4'h7:    r = !fl.n;
            4'h8:    r = fl.f;
            4'h9:    r = !fl.f;
            4'hA:    r = !fl.l && !fl.z;
            4'hB:    r = fl.l || fl.z;
            4'hC:    r = !fl.n && !fl.z;
            4'hD:    r = fl.n || fl.z;
            4'hE:    r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cpu_control_fsm_if.sv
// Control/status bundle between the control FSM (master) and the datapath (slave).
// Carries RAM read data and ALU flags in, every datapath control out.
interface cpu_control_fsm_if;
    logic [15:0] ram_out;
    logic [4:0]  Flags_out;
    logic [15:0] wEnable;
    logic [7:0]  opcode;
    logic [3:0]  Rdest_select;
    logic [3:0]  Rsrc_select;
    logic [15:0] Imm_in;
    logic        Imm_select;
    logic        ram_we;
    logic        en_a;
    logic        lsc_mux_selct;
    logic        fsm_alu_mem_selct;
    logic        pc_en;
    logic        pc_mux_selct;
    logic [15:0] pc_add_k;
    logic        halted;

    modport master (
        input  ram_out, Flags_out,
        output wEnable, opcode, Rdest_select, Rsrc_select, Imm_in, Imm_select,
               ram_we, en_a, lsc_mux_selct, fsm_alu_mem_selct,
               pc_en, pc_mux_selct, pc_add_k, halted
    );

    modport slave (
        output ram_out, Flags_out,
        input  wEnable, opcode, Rdest_select, Rsrc_select, Imm_in, Imm_select,
               ram_we, en_a, lsc_mux_selct, fsm_alu_mem_selct,
               pc_en, pc_mux_selct, pc_add_k, halted
    );
endinterface

// File: rtl/cpu_control_fsm_decode.sv
// Instruction decoder: ir -> class, ALU opcode, extended immediate, register/flag write enables.
// Purely combinational, zero latency, no flow control.
module cpu_control_fsm_decode
    import cpu_control_fsm_pkg::*;
(
    input  logic [15:0] ir,
    output iclass_t     iclass,
    output logic [7:0]  alu_op,
    output logic [15:0] imm,
    output logic        imm_sel,
    output logic        reg_wr,
    output logic        flag_wr
);
    logic [3:0] op;
    logic [3:0] ext;
    logic [7:0] imm8;

    assign op   = ir[15:12];
    assign ext  = ir[7:4];
    assign imm8 = ir[7:0];

    always_comb begin
        iclass  = CL_NOP;
        alu_op  = 8'h00;
        imm     = 16'h0000;
        imm_sel = 1'b0;
        reg_wr  = 1'b0;
        flag_wr = 1'b0;
        // An all-zero word is an R-type encoding but is reserved as the NOP.
        if (ir != 16'h0000) begin
            case (op)
                OP_RTYPE, OP_RTYPE2: begin
                    iclass  = CL_ALU;
                    alu_op  = {op, ext};
                    reg_wr  = (ext != EXT_CMP);
                    flag_wr = (ext == EXT_ADD) || (ext == EXT_SUB) || (ext == EXT_CMP);
                end
                4'h1, 4'h2, 4'h3, OP_ADDI, OP_SUBI, OP_CMPI, 4'hD, OP_LUI: begin
                    iclass  = CL_ALU;
                    alu_op  = {op, 4'h0};
                    imm_sel = 1'b1;
                    reg_wr  = (op != OP_CMPI);
                    flag_wr = (op == OP_ADDI) || (op == OP_SUBI) || (op == OP_CMPI);
                    if (op == OP_LUI)
                        imm = {imm8, 8'h00};
                    else if ((op == OP_ADDI) || (op == OP_SUBI) || (op == OP_CMPI))
                        imm = {{8{imm8[7]}}, imm8};
                    else
                        imm = {8'h00, imm8};
                end
                OP_MEM: begin
                    case (ext)
                        EXT_LOAD: iclass = CL_LOAD;
                        EXT_STOR: iclass = CL_STOR;
                        EXT_WAIT: iclass = CL_WAIT;
                        default:  iclass = CL_NOP;
                    endcase
                end
                OP_BCOND: iclass = CL_BCOND;
                default:  iclass = CL_NOP;
            endcase
        end
    end
endmodule

// File: rtl/cpu_control_fsm.sv
// Multi-cycle fetch/decode/execute sequencer: ALU ops, STOR and branches take 3 cycles, LOAD 4.
// Outputs are Moore plus IR and are forced to zero while reset is high; WAIT parks in HALT until reset.
module cpu_control_fsm
    import cpu_control_fsm_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    cpu_control_fsm_if.master     bus
);
    state_t      state_q;
    logic [15:0] ir_q;
    flags_t      flags_q;

    iclass_t     iclass;
    logic [7:0]  alu_op;
    logic [15:0] imm;
    logic        imm_sel;
    logic        reg_wr;
    logic        flag_wr;
    logic [3:0]  rdest;
    logic [3:0]  rsrc;
    logic [15:0] rdest_onehot;
    logic        taken;

    cpu_control_fsm_decode u_decode (
        .ir      (ir_q),
        .iclass  (iclass),
        .alu_op  (alu_op),
        .imm     (imm),
        .imm_sel (imm_sel),
        .reg_wr  (reg_wr),
        .flag_wr (flag_wr)
    );

    assign rdest        = ir_q[11:8];
    assign rsrc         = ir_q[3:0];
    assign rdest_onehot = 16'd1 << rdest;
    assign taken        = cond_met(ir_q[11:8], flags_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_FETCH;
            ir_q    <= 16'h0000;
            flags_q <= '0;
        end else begin
            unique case (state_q)
                ST_FETCH:  state_q <= ST_DECODE;
                ST_DECODE: begin
                    ir_q    <= bus.ram_out;
                    state_q <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (flag_wr)
                        flags_q <= flags_t'(bus.Flags_out);
                    if (iclass == CL_LOAD)
                        state_q <= ST_LOAD_WB;
                    else if (iclass == CL_WAIT)
                        state_q <= ST_HALT;
                    else
                        state_q <= ST_FETCH;
                end
                ST_LOAD_WB: state_q <= ST_FETCH;
                ST_HALT:    state_q <= ST_HALT;
                default:    state_q <= ST_FETCH;
            endcase
        end
    end

    always_comb begin
        bus.wEnable           = 16'h0000;
        bus.opcode            = 8'h00;
        bus.Rdest_select      = 4'h0;
        bus.Rsrc_select       = 4'h0;
        bus.Imm_in            = 16'h0000;
        bus.Imm_select        = 1'b0;
        bus.ram_we            = 1'b0;
        bus.en_a              = 1'b0;
        bus.lsc_mux_selct     = 1'b0;
        bus.fsm_alu_mem_selct = 1'b0;
        bus.pc_en             = 1'b0;
        bus.pc_mux_selct      = 1'b0;
        bus.pc_add_k          = 16'h0000;
        bus.halted            = 1'b0;
        // Gating on reset keeps an aborted instruction from writing in the reset cycle.
        if (!reset) begin
            unique case (state_q)
                ST_FETCH, ST_DECODE: bus.en_a = 1'b1;
                ST_EXEC: begin
                    case (iclass)
                        CL_ALU: begin
                            bus.opcode       = alu_op;
                            bus.Imm_in       = imm;
                            bus.Imm_select   = imm_sel;
                            bus.Rdest_select = rdest;
                            bus.Rsrc_select  = rsrc;
                            bus.wEnable      = reg_wr ? rdest_onehot : 16'h0000;
                            bus.pc_en        = 1'b1;
                        end
                        CL_LOAD: begin
                            bus.Rsrc_select   = rsrc;
                            bus.lsc_mux_selct = 1'b1;
                            bus.en_a          = 1'b1;
                        end
                        CL_STOR: begin
                            bus.Rsrc_select   = rsrc;
                            bus.Rdest_select  = rdest;
                            bus.lsc_mux_selct = 1'b1;
                            bus.en_a          = 1'b1;
                            bus.ram_we        = 1'b1;
                            bus.pc_en         = 1'b1;
                        end
                        CL_BCOND: begin
                            bus.pc_en = 1'b1;
                            if (taken) begin
                                bus.pc_mux_selct = 1'b1;
                                bus.pc_add_k     = {{8{ir_q[7]}}, ir_q[7:0]};
                            end
                        end
                        CL_WAIT: bus.pc_en = 1'b0;
                        default: bus.pc_en = 1'b1;
                    endcase
                end
                ST_LOAD_WB: begin
                    bus.Rdest_select      = rdest;
                    bus.fsm_alu_mem_selct = 1'b1;
                    bus.wEnable           = rdest_onehot;
                    bus.pc_en             = 1'b1;
                end
                ST_HALT: bus.halted = 1'b1;
                default: bus.halted = 1'b0;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_control_fsm.sv
// Directed bench: a tiny PC/RAM model feeds a program; each retirement is scored against a queue.
module tb_cpu_control_fsm;
    import cpu_control_fsm_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cpu_control_fsm_if bus ();

    cpu_control_fsm dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string       tag;
        int          cycles;
        logic        alu;
        logic [7:0]  op;
        logic        imm_sel;
        logic [15:0] imm;
        logic [15:0] wen;
        logic        br;
        logic        pcm;
        logic [15:0] k;
        logic        st;
        logic        memsel;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    logic [15:0] mem [0:31];
    logic [15:0] pc;
    int          checks = 0;
    int          errors = 0;
    int          cyc_cnt = 0;
    int          ram_we_cnt = 0;
    int          halt_pc_en = 0;

    // Datapath stand-in: PC register and a registered instruction RAM; loads return a fixed word.
    always @(posedge clk) begin
        if (reset)
            pc <= 16'h0000;
        else if (bus.pc_en)
            pc <= bus.pc_mux_selct ? pc + bus.pc_add_k : pc + 16'd1;
        if (bus.en_a)
            bus.ram_out <= bus.lsc_mux_selct ? 16'hBEEF : mem[pc[4:0]];
    end

    // Only the CMP at address 1 sees equal operands (Z set).
    assign bus.Flags_out = (pc == 16'd1) ? 5'b01000 : 5'b00000;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input string tag, input int cyc, input logic alu, input logic [7:0] op,
                                input logic imm_sel, input logic [15:0] imm, input logic [15:0] wen,
                                input logic br, input logic pcm, input logic [15:0] k,
                                input logic st, input logic memsel);
        exp_t r;
        r.tag = tag; r.cycles = cyc; r.alu = alu; r.op = op; r.imm_sel = imm_sel; r.imm = imm;
        r.wen = wen; r.br = br; r.pcm = pcm; r.k = k; r.st = st; r.memsel = memsel;
        return r;
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            cyc_cnt = 0;
        end else begin
            cyc_cnt++;
            if (bus.ram_we) ram_we_cnt++;
            if (bus.pc_en) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL extra_retire: got pc_en with empty queue expected none");
                end else begin
                    e = q.pop_front();
                    chk({e.tag, "_cycles"}, 16'(cyc_cnt), 16'(e.cycles));
                    chk({e.tag, "_wen"}, bus.wEnable, e.wen);
                    chk({e.tag, "_pcmux"}, 16'(bus.pc_mux_selct), 16'(e.pcm));
                    chk({e.tag, "_ramwe"}, 16'(bus.ram_we), 16'(e.st));
                    chk({e.tag, "_lsc"}, 16'(bus.lsc_mux_selct), 16'(e.st));
                    chk({e.tag, "_memsel"}, 16'(bus.fsm_alu_mem_selct), 16'(e.memsel));
                    if (e.alu) begin
                        chk({e.tag, "_opcode"}, 16'(bus.opcode), 16'(e.op));
                        chk({e.tag, "_immsel"}, 16'(bus.Imm_select), 16'(e.imm_sel));
                        if (e.imm_sel) chk({e.tag, "_imm"}, bus.Imm_in, e.imm);
                    end
                    if (e.br) chk({e.tag, "_k"}, bus.pc_add_k, e.k);
                    if (e.st) begin
                        chk({e.tag, "_rsrc"}, 16'(bus.Rsrc_select), 16'h0005);
                        chk({e.tag, "_rdest"}, 16'(bus.Rdest_select), 16'h0004);
                    end
                end
                cyc_cnt = 0;
            end
        end
    end

    initial begin
        int bound;
        reset = 1'b1;
        for (int i = 0; i < 32; i++) mem[i] = 16'h0000;
        mem[0]  = 16'h53FF;  q.push_back(mk("addi", 3, 1, 8'h50, 1, 16'hFFFF, 16'h0008, 0, 0, 16'h0, 0, 0));
        mem[1]  = 16'h01B2;  q.push_back(mk("cmp",  3, 1, 8'h0B, 0, 16'h0,    16'h0000, 0, 0, 16'h0, 0, 0));
        mem[2]  = 16'hC004;  q.push_back(mk("beq",  3, 0, 8'h0,  0, 16'h0,    16'h0000, 1, 1, 16'h0004, 0, 0));
        mem[6]  = 16'hC1FE;  q.push_back(mk("bne_nt", 3, 0, 8'h0, 0, 16'h0,   16'h0000, 0, 0, 16'h0, 0, 0));
        mem[7]  = 16'h0152;  q.push_back(mk("add",  3, 1, 8'h05, 0, 16'h0,    16'h0002, 0, 0, 16'h0, 0, 0));
        mem[8]  = 16'hCE0C;  q.push_back(mk("buc",  3, 0, 8'h0,  0, 16'h0,    16'h0000, 1, 1, 16'h000C, 0, 0));
        mem[20] = 16'hC1FE;  q.push_back(mk("bne_t", 3, 0, 8'h0, 0, 16'h0,    16'h0000, 1, 1, 16'hFFFE, 0, 0));
        mem[18] = 16'hCE04;  q.push_back(mk("buc2", 3, 0, 8'h0,  0, 16'h0,    16'h0000, 1, 1, 16'h0004, 0, 0));
        mem[22] = 16'h4445;  q.push_back(mk("stor", 3, 0, 8'h0,  0, 16'h0,    16'h0000, 0, 0, 16'h0, 1, 0));
        mem[23] = 16'h4605;  q.push_back(mk("load", 4, 0, 8'h0,  0, 16'h0,    16'h0040, 0, 0, 16'h0, 0, 1));
        mem[24] = 16'h0000;  q.push_back(mk("nop",  3, 0, 8'h0,  0, 16'h0,    16'h0000, 0, 0, 16'h0, 0, 0));
        mem[25] = 16'h1234;  q.push_back(mk("andi", 3, 1, 8'h10, 1, 16'h0034, 16'h0004, 0, 0, 16'h0, 0, 0));
        mem[26] = 16'hF2AB;  q.push_back(mk("lui",  3, 1, 8'hF0, 1, 16'hAB00, 16'h0004, 0, 0, 16'h0, 0, 0));
        mem[27] = 16'h9AF0;  q.push_back(mk("subi", 3, 1, 8'h90, 1, 16'hFFF0, 16'h0400, 0, 0, 16'h0, 0, 0));
        mem[28] = 16'h4080;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_wen",    bus.wEnable, 16'h0000);
        chk("rst_ena",    16'(bus.en_a), 16'h0000);
        chk("rst_pcen",   16'(bus.pc_en), 16'h0000);
        chk("rst_halted", 16'(bus.halted), 16'h0000);
        chk("rst_opcode", 16'(bus.opcode), 16'h0000);
        chk("rst_imm",    bus.Imm_in, 16'h0000);
        chk("rst_k",      bus.pc_add_k, 16'h0000);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("fetch_ena", 16'(bus.en_a), 16'h0001);
        chk("fetch_lsc", 16'(bus.lsc_mux_selct), 16'h0000);

        bound = 0;
        while (bound < 400 && !bus.halted) begin
            @(negedge clk);
            bound++;
        end
        chk("halt_reached", 16'(bus.halted), 16'h0001);
        chk("all_retired", 16'(q.size()), 16'h0000);
        chk("ramwe_once", 16'(ram_we_cnt), 16'h0001);

        repeat (25) begin
            @(negedge clk);
            if (bus.pc_en) halt_pc_en++;
        end
        chk("halt_pcen", 16'(halt_pc_en), 16'h0000);
        chk("halt_hold", 16'(bus.halted), 16'h0001);

        mem[0] = 16'h4605;
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        chk("halt_rst", 16'(bus.halted), 16'h0000);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("resume_halted", 16'(bus.halted), 16'h0000);
        chk("resume_ena", 16'(bus.en_a), 16'h0001);
        chk("resume_pc", pc, 16'h0000);
        @(negedge clk);
        @(negedge clk);
        chk("ldexec_lsc", 16'(bus.lsc_mux_selct), 16'h0001);
        chk("ldexec_rsrc", 16'(bus.Rsrc_select), 16'h0005);
        reset = 1'b1;
        #1;
        chk("abort_wen", bus.wEnable, 16'h0000);
        chk("abort_pcen", 16'(bus.pc_en), 16'h0000);
        @(posedge clk);
        @(negedge clk);
        chk("abort_wen2", bus.wEnable, 16'h0000);
        @(posedge clk); #1 reset = 1'b0;
        q.push_back(mk("load2", 4, 0, 8'h0, 0, 16'h0, 16'h0040, 0, 0, 16'h0, 0, 1));
        @(negedge clk);
        chk("refetch_wen", bus.wEnable, 16'h0000);
        chk("refetch_pc", pc, 16'h0000);
        @(negedge clk);
        chk("redecode_wen", bus.wEnable, 16'h0000);
        bound = 0;
        while (bound < 20 && q.size() != 0) begin
            @(negedge clk);
            bound++;
        end
        chk("load2_retired", 16'(q.size()), 16'h0000);
        @(negedge clk);
        chk("load2_pc", pc, 16'h0001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
